tile_plane_fetcher: RTL and testbench

Parametrised successor of the plane address generator. It generates raster H/V timing, then reads per-line X/Y scroll words from VRAM during hblank. During active display it runs a fixed VRAM slot schedule that fetches tilemap entries for NUM_LAYERS layers. It emits GFX ROM line addresses plus attribute and fine-scroll values for the downstream pixel serialiser (k051962-class). Unlike its predecessor, it adds per-line row-scroll per layer, per-layer enable, configurable map size and configurable raster geometry.

---
 rtl/tile_plane_pkg.sv | 25 ++
 rtl/tile_plane_raster.sv | 64 ++++++
 rtl/tile_plane_fetcher.sv | 190 +++++++++++++++++++
 tb/tb_tile_plane_fetcher.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_plane_pkg.sv
// Shared constants and types for the tile plane fetcher.
//   H_TOTAL          : pixels per raster line
//   TILE_LOG2        : log2 of the tile edge in pixels (8x8 tiles)
//   SCR_X_MSB/Y_MSB  : top bit of the X / Y scroll fields in a scroll word
//   YFLIP_BIT        : map entry bit that mirrors the tile vertically
//   layer_idx_t      : layer number (up to four layers)
//   fetch_kind_t     : what the VRAM read issued in the current pixel is for
package tile_plane_pkg;

    localparam int H_TOTAL   = 384;
    localparam int TILE_LOG2 = 3;
    localparam int SCR_X_MSB = 8;
    localparam int SCR_Y_MSB = 7;
    localparam int YFLIP_BIT = 9;

    typedef logic [1:0] layer_idx_t;

    typedef enum logic [1:0] {
        FETCH_NONE  = 2'd0,
        FETCH_SCR_X = 2'd1,
        FETCH_SCR_Y = 2'd2,
        FETCH_MAP   = 2'd3
    } fetch_kind_t;

endpackage

// File: rtl/tile_plane_raster.sv
// Raster timing for the tile plane fetcher.
//   clk, rst  : clock and synchronous active-high reset
//   div       : 2-bit clock divider, one pixel = four clocks
//   pe        : pixel enable, high while div == 3
//   hcnt/vcnt : H counter (H_START..H_START+383) and V counter (V_START..511)
//   hblank    : hcnt within the first HBL_LEN pixels of the line
//   vblank    : vcnt >= VBL_LINE
//   irq       : one-clock pulse in the clock where vcnt becomes VBL_LINE
module tile_plane_raster
    import tile_plane_pkg::*;
#(
    parameter int H_START  = 32,
    parameter int V_START  = 248,
    parameter int HBL_LEN  = 64,
    parameter int VBL_LINE = 496
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] div,
    output logic       pe,
    output logic [8:0] hcnt,
    output logic [8:0] vcnt,
    output logic       hblank,
    output logic       vblank,
    output logic       irq
);

    localparam logic [8:0] H_FIRST = 9'(H_START);
    localparam logic [8:0] H_LAST  = 9'(H_START + H_TOTAL - 1);
    localparam logic [8:0] V_FIRST = 9'(V_START);
    localparam logic [8:0] HBL     = 9'(HBL_LEN);
    localparam logic [8:0] VBL     = 9'(VBL_LINE);

    logic [8:0] vcnt_next;

    assign pe        = (div == 2'd3);
    assign vcnt_next = (vcnt == 9'd511) ? V_FIRST : vcnt + 9'd1;
    assign hblank    = ((hcnt - H_FIRST) < HBL);
    assign vblank    = (vcnt >= VBL);

    always_ff @(posedge clk) begin
        if (rst) begin
            div  <= 2'd0;
            hcnt <= H_FIRST;
            vcnt <= V_FIRST;
            irq  <= 1'b0;
        end else begin
            div <= div + 2'd1;
            irq <= 1'b0;
            if (pe) begin
                if (hcnt == H_LAST) begin
                    hcnt <= H_FIRST;
                    vcnt <= vcnt_next;
                    // Registered together with vcnt so the pulse lines up
                    // with the first clock of the vblank line.
                    irq  <= (vcnt_next == VBL);
                end else begin
                    hcnt <= hcnt + 9'd1;
                end
            end
        end
    end

endmodule

// File: rtl/tile_plane_fetcher.sv
// Tile plane fetcher: raster timing, per-line scroll reads during hblank and
// a fixed per-pixel VRAM slot schedule fetching tilemap entries for
// NUM_LAYERS layers, producing GFX ROM line addresses for the serialiser.
//   clk_24M, RES          : clock, synchronous active-high reset
//   flip                  : flip screen (H tile index and V row inverted)
//   layer_en, rowscr_en   : per-layer fetch enable / per-line scroll select
//   map_base, scr_base    : tilemap bases (one per layer), scroll table base
//   vram_addr/rd/din      : VRAM read port
//   pe, hcnt, vcnt, hblank, vblank, irq : raster timing
//   rom_addr/layer/attr/valid : tile line request for the serialiser
//   fine                  : per-layer fine X scroll
//
// VRAM/ROM timing: vram_rd is a one-clock strobe in the div==0 clock of a
// pixel with vram_addr valid in that same clock; vram_din must be stable by
// the div==3 clock of that pixel. A map fetch produces rom_valid for exactly
// one clock, four clocks after its vram_rd, with rom_addr/layer/attr valid in
// that clock. There is no back-pressure.
module tile_plane_fetcher
    import tile_plane_pkg::*;
#(
    parameter int NUM_LAYERS = 2,
    parameter int MAP_W_LOG2 = 6,
    parameter int MAP_H_LOG2 = 5,
    parameter int CODE_W     = 8,
    parameter int VRAM_AW    = 13,
    parameter int H_START    = 32,
    parameter int V_START    = 248,
    parameter int HBL_LEN    = 64,
    parameter int VBL_LINE   = 496
) (
    input  logic                          clk_24M,
    input  logic                          RES,
    input  logic                          flip,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [NUM_LAYERS-1:0]         rowscr_en,
    input  logic [NUM_LAYERS*VRAM_AW-1:0] map_base,
    input  logic [VRAM_AW-1:0]            scr_base,
    output logic [VRAM_AW-1:0]            vram_addr,
    output logic                          vram_rd,
    input  logic [15:0]                   vram_din,
    output logic                          pe,
    output logic [8:0]                    hcnt,
    output logic [8:0]                    vcnt,
    output logic                          hblank,
    output logic                          vblank,
    output logic                          irq,
    output logic [CODE_W+2:0]             rom_addr,
    output logic [1:0]                    rom_layer,
    output logic [7:0]                    rom_attr,
    output logic                          rom_valid,
    output logic [NUM_LAYERS*3-1:0]       fine
);

    localparam logic [8:0] H_FIRST = 9'(H_START);

    logic [1:0] div;

    tile_plane_raster #(
        .H_START (H_START),
        .V_START (V_START),
        .HBL_LEN (HBL_LEN),
        .VBL_LINE(VBL_LINE)
    ) u_raster (
        .clk   (clk_24M),
        .rst   (RES),
        .div   (div),
        .pe    (pe),
        .hcnt  (hcnt),
        .vcnt  (vcnt),
        .hblank(hblank),
        .vblank(vblank),
        .irq   (irq)
    );

    logic [NUM_LAYERS-1:0][SCR_X_MSB:0] sx;
    logic [NUM_LAYERS-1:0][SCR_Y_MSB:0] sy;

    // Read issued at div==0, remembered until its data arrives at div==3.
    fetch_kind_t pend_kind;
    layer_idx_t  pend_layer;
    logic [2:0]  pend_line;

    fetch_kind_t        kind;
    layer_idx_t         lyr;
    logic [2:0]         line;
    logic [VRAM_AW-1:0] addr;
    logic [8:0]         hpos;
    logic [7:0]         vline;
    logic [8:0]         col;
    logic [7:0]         row;
    logic               en_sel;
    logic               row_sel;
    logic [VRAM_AW-1:0] base_sel;
    logic [8:0]         sx_sel;
    logic [7:0]         sy_sel;

    assign hpos = hcnt - H_FIRST;

    // Slot decode for the current pixel.
    always_comb begin
        kind     = FETCH_NONE;
        line     = 3'd0;
        addr     = '0;
        en_sel   = 1'b0;
        row_sel  = 1'b0;
        base_sel = '0;
        sx_sel   = '0;
        sy_sel   = '0;
        vline    = vcnt[7:0] ^ {8{flip}};
        // hblank: two scroll words per layer; active: slot p = hcnt[2:0].
        lyr      = hblank ? layer_idx_t'(hpos[2:1]) : layer_idx_t'(hcnt[1:0]);
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (lyr == layer_idx_t'(i)) begin
                en_sel   = layer_en[i];
                row_sel  = rowscr_en[i];
                base_sel = map_base[i*VRAM_AW +: VRAM_AW];
                sx_sel   = sx[i];
                sy_sel   = sy[i];
            end
        end
        // The +16 looks two tiles ahead of the pixel being shown.
        col = (hpos ^ {9{flip}}) + 9'd16 + sx_sel;
        row = vline + sy_sel;
        if (hblank) begin
            if ((hpos < 9'(2*NUM_LAYERS)) && en_sel) begin
                kind = hpos[0] ? FETCH_SCR_Y : FETCH_SCR_X;
                addr = scr_base + VRAM_AW'({lyr, (row_sel ? vline : 8'd0), hpos[0]});
            end
        end else if ((hcnt[2:0] < 3'(NUM_LAYERS)) && en_sel) begin
            kind = FETCH_MAP;
            line = row[2:0];
            addr = base_sel + VRAM_AW'({row[TILE_LOG2 +: MAP_H_LOG2],
                                        col[TILE_LOG2 +: MAP_W_LOG2]});
        end
    end

    assign vram_rd   = (div == 2'd0) && (kind != FETCH_NONE) && !RES;
    assign vram_addr = vram_rd ? addr : '0;

    always_comb begin
        fine = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            fine[i*3 +: 3] = sx[i][2:0] ^ {3{flip}};
        end
    end

    always_ff @(posedge clk_24M) begin
        if (RES) begin
            sx         <= '0;
            sy         <= '0;
            pend_kind  <= FETCH_NONE;
            pend_layer <= '0;
            pend_line  <= 3'd0;
            rom_addr   <= '0;
            rom_layer  <= 2'd0;
            rom_attr   <= 8'd0;
            rom_valid  <= 1'b0;
        end else begin
            rom_valid <= 1'b0;
            if (div == 2'd0) begin
                pend_kind  <= kind;
                pend_layer <= lyr;
                pend_line  <= line;
            end
            if (div == 2'd3) begin
                case (pend_kind)
                    FETCH_SCR_X: begin
                        for (int i = 0; i < NUM_LAYERS; i++) begin
                            if (pend_layer == layer_idx_t'(i)) sx[i] <= vram_din[SCR_X_MSB:0];
                        end
                    end
                    FETCH_SCR_Y: begin
                        for (int i = 0; i < NUM_LAYERS; i++) begin
                            if (pend_layer == layer_idx_t'(i)) sy[i] <= vram_din[SCR_Y_MSB:0];
                        end
                    end
                    FETCH_MAP: begin
                        rom_addr  <= {vram_din[CODE_W-1:0], pend_line ^ {3{vram_din[YFLIP_BIT]}}};
                        rom_attr  <= vram_din[15:8];
                        rom_layer <= pend_layer;
                        rom_valid <= 1'b1;
                    end
                    default: ;
                endcase
                pend_kind <= FETCH_NONE;
            end
        end
    end

endmodule

// File: tb/tb_tile_plane_fetcher.sv
`timescale 1ns/1ps
module tb_tile_plane_fetcher;

  localparam int NL      = 2;
  localparam int CW      = 8;
  localparam int VAW     = 13;
  localparam int H_START = 32;
  localparam int V_START = 248;
  localparam int HBL     = 64;
  localparam int VBL     = 251;
  localparam int H_TOT   = 384;
  localparam int W       = 2 + 8 + CW + 3;

  // ---------------- clock / reset ----------------
  logic clk_24M = 1'b0;
  always #5 clk_24M = ~clk_24M;

  logic              RES = 1'b1;
  logic              flip = 1'b0;
  logic [NL-1:0]     layer_en = '0;
  logic [NL-1:0]     rowscr_en = '0;
  logic [NL*VAW-1:0] map_base = '0;
  logic [VAW-1:0]    scr_base = '0;
  logic [VAW-1:0]    vram_addr;
  logic              vram_rd;
  logic [15:0]       vram_din = '0;
  logic              pe, hblank, vblank, irq;
  logic [8:0]        hcnt, vcnt;
  logic [CW+2:0]     rom_addr;
  logic [1:0]        rom_layer;
  logic [7:0]        rom_attr;
  logic              rom_valid;
  logic [NL*3-1:0]   fine;

  tile_plane_fetcher #(.NUM_LAYERS(NL), .VBL_LINE(VBL)) dut (
    .clk_24M(clk_24M), .RES(RES), .flip(flip), .layer_en(layer_en),
    .rowscr_en(rowscr_en), .map_base(map_base), .scr_base(scr_base),
    .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_din(vram_din),
    .pe(pe), .hcnt(hcnt), .vcnt(vcnt), .hblank(hblank), .vblank(vblank),
    .irq(irq), .rom_addr(rom_addr), .rom_layer(rom_layer),
    .rom_attr(rom_attr), .rom_valid(rom_valid), .fine(fine)
  );

  // ---------------- reference state ----------------
  logic [15:0]    mem [8192];
  logic [VAW-1:0] mb [NL];
  int             sx_m [NL];
  int             sy_m [NL];
  int             t;
  int             sp_kind, sp_l;
  logic [15:0]    sp_dat;
  logic           rd_seen;
  logic [VAW-1:0] rd_addr;

  // scoreboard: expected rom payload {layer, attr, rom_addr} and due clock
  logic [W-1:0] exp_q[$];
  int           due_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=0x%0h exp=0x%0h", tag, t, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_bases();
    for (int l = 0; l < NL; l++) map_base[l*VAW +: VAW] = mb[l];
  endtask

  task automatic random_cfg(input logic f);
    flip      = f;
    layer_en  = NL'($urandom_range(1, (1 << NL) - 1));
    rowscr_en = NL'($urandom_range(0, (1 << NL) - 1));
    scr_base  = VAW'($urandom_range(0, 8191));
    for (int l = 0; l < NL; l++) mb[l] = VAW'($urandom_range(0, 8191));
    apply_bases();
  endtask

  task automatic do_reset(input int n);
    RES = 1'b1;
    repeat (n) begin
      @(posedge clk_24M);
      #1;
    end
    check_eq("rst_hcnt", hcnt, H_START);
    check_eq("rst_vcnt", vcnt, V_START);
    check_eq("rst_rom_valid", rom_valid, 0);
    check_eq("rst_vram_rd", vram_rd, 0);
    check_eq("rst_pe", pe, 0);
    check_eq("rst_irq", irq, 0);
    RES = 1'b0;
    t = 0;
    exp_q.delete();
    due_q.delete();
    for (int l = 0; l < NL; l++) begin
      sx_m[l] = 0;
      sy_m[l] = 0;
    end
    sp_kind = 0;
  endtask

  // Reference model for the clock t (clocks since reset release).
  task automatic model_cycle();
    int pix, d, k, ln, v, l, w, p, a, x, y, rs, vl;
    logic [15:0]   dw;
    logic [NL*3-1:0] fexp;
    logic          exp_rd, exp_v;
    pix = t / 4;
    d   = t % 4;
    k   = pix % H_TOT;
    ln  = pix / H_TOT;
    v   = V_START + (ln % (512 - V_START));
    vl  = (v % 256) ^ (flip ? 255 : 0);

    check_eq("hcnt", hcnt, H_START + k);
    check_eq("vcnt", vcnt, v);
    check_eq("pe", pe, d == 3);
    check_eq("hblank", hblank, k < HBL);
    check_eq("vblank", vblank, v >= VBL);
    check_eq("irq", irq, (v == VBL) && (k == 0) && (d == 0) && (t > 0));

    for (int i = 0; i < NL; i++) fexp[i*3 +: 3] = 3'(sx_m[i] % 8) ^ (flip ? 3'd7 : 3'd0);
    check_eq("fine", fine, fexp);

    exp_rd = 1'b0;
    a = 0;
    if (d == 0) begin
      if (k < HBL) begin
        if (k < 2 * NL) begin
          l = k / 2;
          w = k % 2;
          if (layer_en[l]) begin
            rs = rowscr_en[l] ? vl : 0;
            a  = (int'(scr_base) + l * 512 + rs * 2 + w) % 8192;
            exp_rd  = 1'b1;
            sp_kind = w + 1;
            sp_l    = l;
            sp_dat  = mem[a];
          end
        end
      end else begin
        p = (H_START + k) % 8;
        if (p < NL && layer_en[p]) begin
          x  = ((k ^ (flip ? 511 : 0)) + 16 + sx_m[p]) % 512;
          y  = (vl + sy_m[p]) % 256;
          a  = (int'(mb[p]) + ((y / 8) % 32) * 64 + (x / 8) % 64) % 8192;
          dw = mem[a];
          exp_rd = 1'b1;
          exp_q.push_back({2'(p), dw[15:8], dw[CW-1:0], 3'((y % 8) ^ (dw[9] ? 7 : 0))});
          due_q.push_back(t + 4);
        end
      end
    end
    check_eq("vram_rd", vram_rd, exp_rd);
    if (exp_rd) check_eq("vram_addr", vram_addr, a);

    exp_v = (due_q.size() > 0) && (due_q[0] == t);
    check_eq("rom_valid", rom_valid, exp_v);
    if (exp_v) begin
      check_eq("rom_out", {rom_layer, rom_attr, rom_addr}, exp_q[0]);
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end

    if (d == 3 && sp_kind != 0) begin
      if (sp_kind == 1) sx_m[sp_l] = int'(sp_dat) % 512;
      else              sy_m[sp_l] = int'(sp_dat) % 256;
      sp_kind = 0;
    end

    rd_seen = vram_rd;
    rd_addr = vram_addr;
  endtask

  // One clock: check at the falling edge, answer VRAM reads after the rise.
  task automatic step();
    @(negedge clk_24M);
    model_cycle();
    @(posedge clk_24M);
    #1;
    if (rd_seen) vram_din = mem[rd_addr];
    t++;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int found;
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom_range(0, 65535));

    // Reset values, first line, line increment, irq at vblank entry.
    flip = 1'b0; layer_en = '1; rowscr_en = '0; scr_base = 13'h1800;
    mb[0] = 13'h0800; mb[1] = 13'h1000; apply_bases();
    mem[13'h1800] = 16'h0005;
    mem[13'h1801] = 16'h0010;
    do_reset(3);
    run_cycles(4 * H_TOT * 4);

    // Flipped screen with random layers/row scroll.
    random_cfg(1'b1);
    do_reset(2);
    run_cycles(2 * H_TOT * 4);

    // Only layer 1 enabled.
    random_cfg(1'b0);
    layer_en = 2'b10;
    do_reset(2);
    run_cycles(2 * H_TOT * 4);

    // Large X scroll so the map column wraps.
    random_cfg(1'b0);
    layer_en = '1; rowscr_en = '0;
    for (int l = 0; l < NL; l++) mem[(int'(scr_base) + l * 512) % 8192] = 16'h01F8;
    do_reset(2);
    run_cycles(2 * H_TOT * 4);

    // layer_en changed mid-line.
    random_cfg(1'b1);
    do_reset(2);
    run_cycles(200 * 4 + 1);
    layer_en = NL'($urandom_range(0, (1 << NL) - 1));
    run_cycles(2 * H_TOT * 4);

    // Reset landing on div==1 of a layer-0 map fetch.
    random_cfg(1'b0);
    layer_en = '1;
    do_reset(2);
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      step();
      if ((t % 4 == 1) && ((t / 4) % H_TOT >= HBL) && ((H_START + (t / 4) % H_TOT) % 8 == 0))
        found = 1;
    end
    check_eq("mid_reset_slot_found", found, 1);
    do_reset(1);
    run_cycles(H_TOT * 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
